// File: rtl/decoder_seq.sv
// rtl/decoder_seq.sv - registered one-hot decoder with direct, scan-up/down and hold modes
//
// Purpose: drives a registered one-hot select bus from either a direct index or
// an internal index that steps up/down every DIV+1 enabled cycles.
//
// Ports:
//   i_clk    clock, all state changes on the rising edge
//   i_rst    synchronous active-high reset
//   i_e      enable; low blanks o_a/o_valid/o_wrap and freezes index and divider
//   i_d      select index (direct) or start index (scan LOAD)
//   i_mode   00 direct, 01 scan-up, 10 scan-down, 11 hold
//   i_div    scan step period minus one, in clock cycles
//   i_load   scan modes: load i_d into the index, takes precedence over a step
//   o_a      registered one-hot decode of o_idx, or all zeros when blanked
//   o_idx    current registered index
//   o_valid  high iff o_a is one-hot
//   o_wrap   one-cycle pulse after a scan step that wraps around
module decoder_seq #(
    parameter int N     = 2,
    parameter int DIV_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_e,
    input  logic [N-1:0]       i_d,
    input  logic [1:0]         i_mode,
    input  logic [DIV_W-1:0]   i_div,
    input  logic               i_load,
    output logic [(2**N)-1:0]  o_a,
    output logic [N-1:0]       o_idx,
    output logic               o_valid,
    output logic               o_wrap
);

    localparam int K = 2**N;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

    mode_t            w_mode;
    mode_t            r_pmode;
    logic [DIV_W-1:0] r_cnt;
    logic [N-1:0]     r_idx;
    logic [K-1:0]     r_a;
    logic             r_valid;
    logic             r_wrap;

    logic             w_mode_chg;
    logic             w_step_due;
    logic [N-1:0]     w_idx_up;
    logic [N-1:0]     w_idx_dn;

    function automatic logic [K-1:0] hot(input logic [N-1:0] idx);
        hot      = '0;
        hot[idx] = 1'b1;
    endfunction

    assign w_mode     = mode_t'(i_mode);
    assign w_mode_chg = (w_mode != r_pmode);
    // >= rather than == so that lowering DIV below the running count steps at once
    assign w_step_due = (r_cnt >= i_div);
    assign w_idx_up   = r_idx + N'(1);
    assign w_idx_dn   = r_idx - N'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pmode <= MODE_DIRECT;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_a     <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            // Mode history tracks every edge, including disabled ones
            r_pmode <= w_mode;
            if (!i_e) begin
                r_a     <= '0;
                r_valid <= 1'b0;
                r_wrap  <= 1'b0;
            end else begin
                r_valid <= 1'b1;
                r_wrap  <= 1'b0;
                case (w_mode)
                    MODE_DIRECT: begin
                        r_idx <= i_d;
                        r_a   <= hot(i_d);
                        r_cnt <= '0;
                    end
                    MODE_UP, MODE_DOWN: begin
                        if (i_load) begin
                            r_idx <= i_d;
                            r_a   <= hot(i_d);
                            r_cnt <= '0;
                        end else if (w_mode_chg) begin
                            // Entering a scan mode restarts the period without stepping
                            r_cnt <= '0;
                            r_a   <= hot(r_idx);
                        end else if (!w_step_due) begin
                            r_cnt <= r_cnt + DIV_W'(1);
                            r_a   <= hot(r_idx);
                        end else begin
                            r_cnt <= '0;
                            if (w_mode == MODE_UP) begin
                                r_idx  <= w_idx_up;
                                r_a    <= hot(w_idx_up);
                                r_wrap <= (r_idx == {N{1'b1}});
                            end else begin
                                r_idx  <= w_idx_dn;
                                r_a    <= hot(w_idx_dn);
                                r_wrap <= (r_idx == '0);
                            end
                        end
                    end
                    default: begin
                        r_a <= hot(r_idx);
                        if (w_mode_chg) begin
                            r_cnt <= '0;
                        end
                    end
                endcase
            end
        end
    end

    assign o_a     = r_a;
    assign o_idx   = r_idx;
    assign o_valid = r_valid;
    assign o_wrap  = r_wrap;

endmodule

// File: tb/tb_decoder_seq.sv
// tb/tb_decoder_seq.sv - directed and random checks of decoder_seq against a behavioural model
module tb_decoder_seq;

    localparam int N     = 2;
    localparam int DIV_W = 8;
    localparam int K     = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             e;
    logic             load;
    logic [N-1:0]     d;
    logic [1:0]       mode;
    logic [DIV_W-1:0] div;
    logic [K-1:0]     a;
    logic [N-1:0]     idx;
    logic             valid;
    logic             wrap;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    int m_idx, m_cnt, m_pmode, m_a, m_valid, m_wrap;

    decoder_seq #(.N(N), .DIV_W(DIV_W)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_e    (e),
        .i_d    (d),
        .i_mode (mode),
        .i_div  (div),
        .i_load (load),
        .o_a    (a),
        .o_idx  (idx),
        .o_valid(valid),
        .o_wrap (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        int old_pmode;
        if (rst) begin
            m_idx = 0; m_cnt = 0; m_pmode = 0;
            m_a = 0; m_valid = 0; m_wrap = 0;
        end else begin
            old_pmode = m_pmode;
            m_pmode   = int'(mode);
            if (!e) begin
                m_a = 0; m_valid = 0; m_wrap = 0;
            end else begin
                m_valid = 1;
                m_wrap  = 0;
                if (mode == 2'd0) begin
                    m_idx = int'(d); m_cnt = 0;
                end else if (mode == 2'd3) begin
                    if (int'(mode) != old_pmode) m_cnt = 0;
                end else if (load) begin
                    m_idx = int'(d); m_cnt = 0;
                end else if (int'(mode) != old_pmode) begin
                    m_cnt = 0;
                end else if (m_cnt < int'(div)) begin
                    m_cnt = m_cnt + 1;
                end else begin
                    m_cnt = 0;
                    if (mode == 2'd1) begin
                        m_idx  = (m_idx + 1) % K;
                        m_wrap = (m_idx == 0) ? 1 : 0;
                    end else begin
                        m_idx  = (m_idx + K - 1) % K;
                        m_wrap = (m_idx == K - 1) ? 1 : 0;
                    end
                end
                m_a = 2 ** m_idx;
            end
        end
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        chk({tag, ".a"},     32'(a),     32'(m_a));
        chk({tag, ".idx"},   32'(idx),   32'(m_idx));
        chk({tag, ".valid"}, 32'(valid), 32'(m_valid));
        chk({tag, ".wrap"},  32'(wrap),  32'(m_wrap));
        chk({tag, ".onehot"}, 32'($onehot0(a) && ((a != '0) == valid)), 32'd1);
    endtask

    initial begin
        logic [K-1:0] dn_seq [4];
        logic         dn_wrap [4];
        dn_seq  = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        dn_wrap = '{1'b1, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; e = 1'b1; load = 1'b1; d = 2'd3; mode = 2'd1; div = '0;
        tick("reset0");
        tick("reset1");
        chk("reset_a", 32'(a), 32'd0);
        chk("reset_idx", 32'(idx), 32'd0);

        // Direct decode, one-cycle latency
        rst = 1'b0; e = 1'b1; load = 1'b0; mode = 2'd0; d = 2'd2;
        tick("direct");
        chk("direct_a", 32'(a), 32'b0100);
        chk("direct_idx", 32'(idx), 32'd2);
        d = 2'd1;
        tick("direct2");
        chk("direct2_a", 32'(a), 32'b0010);

        // Scan up, DIV=2, load 3, wrap after three cycles
        mode = 2'd1; div = 8'd2; load = 1'b1; d = 2'd3;
        tick("up_load");
        chk("up_load_a", 32'(a), 32'b1000);
        load = 1'b0;
        tick("up_c1");
        tick("up_c2");
        tick("up_step");
        chk("up_wrap_a", 32'(a), 32'b0001);
        chk("up_wrap_pulse", 32'(wrap), 32'd1);
        tick("up_c3");
        chk("up_wrap_clear", 32'(wrap), 32'd0);
        tick("up_c4");
        tick("up_step2");
        chk("up_step2_a", 32'(a), 32'b0010);

        // Scan down, DIV=0, from index 0
        mode = 2'd0; d = 2'd0;
        tick("dn_prep");
        mode = 2'd2; div = 8'd0;
        tick("dn_enter");
        chk("dn_enter_a", 32'(a), 32'b0001);
        for (int i = 0; i < 4; i++) begin
            tick("dn_run");
            chk("dn_seq_a", 32'(a), 32'(dn_seq[i]));
            chk("dn_seq_wrap", 32'(wrap), 32'(dn_wrap[i]));
        end

        // Disable mid-scan then resume
        mode = 2'd1; div = 8'd3;
        for (int i = 0; i < 3; i++) tick("en_pre");
        e = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick("en_off");
            chk("en_off_a", 32'(a), 32'd0);
        end
        e = 1'b1;
        for (int i = 0; i < 6; i++) tick("en_resume");

        // Hold mode, then lowering DIV below the running count
        mode = 2'd3;
        for (int i = 0; i < 3; i++) tick("hold");
        mode = 2'd1; div = 8'd6;
        for (int i = 0; i < 4; i++) tick("div_hi");
        div = 8'd1;
        tick("div_lowered");

        // LOAD on a step cycle, then reset wins over everything
        div = 8'd1;
        tick("ld_c0");
        load = 1'b1; d = 2'd1;
        tick("ld_step");
        chk("ld_step_a", 32'(a), 32'b0010);
        load = 1'b0;
        tick("ld_after");
        rst = 1'b1; e = 1'b1; mode = 2'd0; d = 2'd3;
        tick("rst_force");
        chk("rst_force_a", 32'(a), 32'd0);
        chk("rst_force_valid", 32'(valid), 32'd0);
        rst = 1'b0; mode = 2'd1; div = 8'd2;
        for (int i = 0; i < 8; i++) tick("post_rst");

        // Random stimulus
        for (int i = 0; i < 10000; i++) begin
            rst  = ($urandom_range(0, 199) == 0);
            e    = ($urandom_range(0, 9) != 0);
            load = ($urandom_range(0, 7) == 0);
            d    = N'($urandom);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 7) == 0)
                div = ($urandom_range(0, 15) == 0) ? DIV_W'($urandom) : DIV_W'($urandom_range(0, 4));
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/decoder_seq.md
DECODER_SEQ -- requirements
Module: decoder_seq

Interface
REQ-001 Parameter N, default 2, select width; output count is 2**N.
REQ-002 Parameter DIV_W, default 8, scan-divider width.
REQ-003 CLK  input  1  clock; all state changes on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 E  input  1  enable; 0 blanks outputs and freezes scan.
REQ-006 D  input  N  select index (direct mode) / scan start index (LOAD).
REQ-007 MODE  input  2  00 direct, 01 scan-up, 10 scan-down, 11 hold.
REQ-008 DIV  input  DIV_W  scan step period minus 1, in CLK cycles.
REQ-009 LOAD  input  1  in scan modes, load D into index.
REQ-010 A  output  2**N  registered one-hot decode of IDX, or all zeros.
REQ-011 IDX  output  N  current registered index.
REQ-012 VALID  output  1  1 iff A is one-hot (not blanked).
REQ-013 WRAP  output  1  one-cycle pulse on scan wrap-around.

Function
REQ-014 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-015 Internal state: IDX register, DIV_W-bit divider CNT, previous-MODE register PMODE.
REQ-016 Priority per edge SHALL be: RST > E=0 > MODE action.
REQ-017 E=0: A<=0, VALID<=0, WRAP<=0; IDX, CNT held.
REQ-018 Direct (00), E=1: IDX<=D, A<=1<<D, VALID<=1, CNT<=0; latency D->A exactly 1 cycle.
REQ-019 Scan (01/10), E=1, LOAD=1: IDX<=D, CNT<=0, A<=1<<D, VALID<=1, WRAP<=0; LOAD beats step.
REQ-020 Scan, E=1, LOAD=0, CNT<DIV: CNT<=CNT+1; IDX, A held; VALID<=1.
REQ-021 Scan, E=1, LOAD=0, CNT>=DIV: CNT<=0; IDX<=IDX+1 (01) or IDX-1 (10), modulo 2**N; A<=one-hot of new IDX.
REQ-022 WRAP SHALL be 1 for exactly the cycle after a step 2**N-1->0 (up) or 0->2**N-1 (down); else 0.
REQ-023 DIV=0 SHALL step every enabled cycle; DIV lowered below CNT SHALL step on the next enabled edge (>= compare).
REQ-024 Hold (11), E=1: IDX, CNT held; A<=one-hot of IDX, VALID<=1; WRAP<=0.
REQ-025 When MODE != PMODE, CNT SHALL be cleared that edge (no step taken); PMODE<=MODE every edge.
REQ-026 Re-assertion of E SHALL restore A to one-hot of held IDX one cycle later, CNT resuming from held value.
REQ-027 A SHALL always be zero or exactly one-hot; A==0 iff VALID==0.
REQ-028 N=1 SHALL yield 2 outputs with identical rules; N up to 6 SHALL be supported.

Reset
REQ-029 RST=1 at an edge: A=0, IDX=0, VALID=0, WRAP=0, CNT=0, PMODE=00, regardless of other inputs.
REQ-030 Reset mid-scan SHALL discard progress; first step after release follows a full DIV+1 period from CNT=0.

Verification
REQ-031 Reset then E=1, MODE=00, D=2 (N=2) -> next cycle A=0100, IDX=2, VALID=1.
REQ-032 MODE=01, DIV=2, LOAD pulse D=3 -> A=1000; 3 cycles later A=0001 with WRAP=1 for 1 cycle; steps every 3 cycles.
REQ-033 MODE=10, DIV=0, IDX=0 -> A sequence 1000,0100,0010,0001 per cycle, WRAP=1 on the 0->3 step only.
REQ-034 Scanning, E=0 for 5 cycles -> A=0, VALID=0, IDX/CNT frozen; E=1 -> A one-hot of same IDX, step timing resumes.
REQ-035 Scan with LOAD=1 on the step cycle and RST=1 with E=1,MODE=00 -> LOAD value wins step; RST forces all-zero outputs.
REQ-036 Random E/MODE/D/LOAD/DIV for 10k cycles vs reference model -> A, IDX, VALID, WRAP match; one-hot invariant never violated.
